// File: rtl/instruction_fetch.sv
// BeeF fetch front end: owns the PC, reads the synchronous instruction memory and
// buffers {word, addr} in a 2-deep FIFO. Define BEEF_FETCH_PERF_EN to add fetch_count.
module instruction_fetch #(
    parameter int         PCWidth  = 16,
    parameter logic [8:0] HaltWord = 9'h1FF,
    parameter logic [8:0] NopWord  = 9'h000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PCWidth-1:0] imem_addr,
    input  logic [8:0]         imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PCWidth-1:0] redirect_pc,
    input  logic               redirect_dir,
    output logic [8:0]         Instruction,
    output logic               instr_valid,
    output logic [PCWidth-1:0] instr_pc,
    output logic               halted
`ifdef BEEF_FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    logic [PCWidth-1:0] pc_q, pc_d;
    logic               dir_q, dir_d;
    logic [1:0]         count_q, count_d;
    logic               inflight_q, inflight_d;
    logic               drop_q, drop_d;
    logic               halt_seen_q, halt_seen_d;
    logic [PCWidth-1:0] req_addr_q, req_addr_d;
    logic [8:0]         fifo_word_q [2];
    logic [8:0]         fifo_word_d [2];
    logic [PCWidth-1:0] fifo_addr_q [2];
    logic [PCWidth-1:0] fifo_addr_d [2];

    logic               pop;
    logic               push;
    logic               redirect_take;
    logic [2:0]         occupancy;
    logic               wr_sel;

    assign instr_valid = (count_q != 2'd0);
    assign Instruction = instr_valid ? fifo_word_q[0] : NopWord;
    assign instr_pc    = instr_valid ? fifo_addr_q[0] : '0;
    assign halted      = halt_seen_q;
    assign imem_addr   = pc_q;

    assign pop           = instr_valid & ~stall;
    assign redirect_take = redirect_valid & ~halt_seen_q;
    assign push          = inflight_q & ~drop_q;

    // Slots that are full or already promised to an outstanding read after this edge.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign imem_req  = ~halt_seen_q & ~redirect_valid & (occupancy < 3'd2);

    // A response only ever lands while count <= 1, so the slot is 0 unless one word stays.
    assign wr_sel = ~pop & (count_q == 2'd1);

    always_comb begin
        pc_d           = pc_q;
        dir_d          = dir_q;
        count_d        = count_q;
        inflight_d     = imem_req;
        drop_d         = drop_q;
        halt_seen_d    = halt_seen_q;
        req_addr_d     = req_addr_q;
        fifo_word_d[0] = fifo_word_q[0];
        fifo_word_d[1] = fifo_word_q[1];
        fifo_addr_d[0] = fifo_addr_q[0];
        fifo_addr_d[1] = fifo_addr_q[1];

        if (redirect_take) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            dir_d   = redirect_dir;
            drop_d  = imem_req;
        end else begin
            if (inflight_q && drop_q) begin
                drop_d = 1'b0;
            end

            if (pop) begin
                fifo_word_d[0] = fifo_word_q[1];
                fifo_addr_d[0] = fifo_addr_q[1];
            end

            if (push) begin
                fifo_word_d[wr_sel] = imem_data;
                fifo_addr_d[wr_sel] = req_addr_q;
                if (imem_data == HaltWord) begin
                    halt_seen_d = 1'b1;
                end
            end

            count_d = count_q + {1'b0, push} - {1'b0, pop};

            if (imem_req) begin
                req_addr_d = pc_q;
                pc_d       = dir_q ? (pc_q - 1'b1) : (pc_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= '0;
            dir_q          <= 1'b0;
            count_q        <= 2'd0;
            inflight_q     <= 1'b0;
            drop_q         <= 1'b0;
            halt_seen_q    <= 1'b0;
            req_addr_q     <= '0;
            fifo_word_q[0] <= '0;
            fifo_word_q[1] <= '0;
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
        end else begin
            pc_q           <= pc_d;
            dir_q          <= dir_d;
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            drop_q         <= drop_d;
            halt_seen_q    <= halt_seen_d;
            req_addr_q     <= req_addr_d;
            fifo_word_q[0] <= fifo_word_d[0];
            fifo_word_q[1] <= fifo_word_d[1];
            fifo_addr_q[0] <= fifo_addr_d[0];
            fifo_addr_q[1] <= fifo_addr_d[1];
        end
    end

`ifdef BEEF_FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // A pop on a redirect edge is overridden by the flush, so it is not counted.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop && !redirect_take && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    // No pop counter in this build.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a request tracker queues the expected
// {word, addr} per fetch, a monitor pops and compares every delivered instruction.
module tb_instruction_fetch;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] NOP  = 9'h000;

    typedef struct packed {
        logic [8:0]  word;
        logic [15:0] addr;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [8:0]  imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        redirect_dir;
    logic [8:0]  Instruction;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic        halted;
    logic [31:0] fetch_count;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_dir   (redirect_dir),
        .Instruction    (Instruction),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .halted         (halted)
`ifdef BEEF_FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

`ifndef BEEF_FETCH_PERF_EN
    assign fetch_count = 32'd0;
`endif

    logic [8:0] mem [0:65535];

    always @(posedge clk) begin
        if (imem_req) imem_data <= mem[imem_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          failures;
    int          delivered;
    bit          halt_delivered;

    // Reference model: everything requested and not yet delivered or flushed.
    item_t       q[$];
    logic [15:0] pc_m;
    logic        dir_m;
    bit          inflight_m;
    bit          halt_m;
    int          fc_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pc_m       = 16'h0000;
        dir_m      = 1'b0;
        inflight_m = 0;
        halt_m     = 0;
        fc_m       = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_imem_req"},    {31'd0, imem_req},    32'd1);
        check({tag, "_imem_addr"},   {16'd0, imem_addr},   32'd0);
        check({tag, "_instruction"}, {23'd0, Instruction}, {23'd0, NOP});
        check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr_pc"},    {16'd0, instr_pc},    32'd0);
        check({tag, "_halted"},      {31'd0, halted},      32'd0);
`ifdef BEEF_FETCH_PERF_EN
        check({tag, "_fetch_count"}, fetch_count,          32'd0);
`endif
    endtask

    // Monitor: outputs seen mid-cycle against the scoreboard head.
    always begin
        int arrived;
        @(negedge clk);
        if (rst_n) begin
            arrived = q.size() - int'(inflight_m);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, (arrived > 0)});
            check("halted", {31'd0, halted}, {31'd0, halt_m});
`ifdef BEEF_FETCH_PERF_EN
            check("fetch_count", fetch_count, fc_m);
`endif
            if (arrived > 0) begin
                check("instruction", {23'd0, Instruction}, {23'd0, q[0].word});
                check("instr_pc", {16'd0, instr_pc}, {16'd0, q[0].addr});
                if (!stall) begin
                    if (q[0].word == HALT) halt_delivered = 1;
                    void'(q.pop_front());
                    delivered++;
                    if (!(redirect_valid && !halt_m)) fc_m++;
                end
            end else begin
                check("nop_word", {23'd0, Instruction}, {23'd0, NOP});
            end
        end
    end

    // Request tracker: applies the coming edge to the model and queues new fetches.
    always begin
        bit req_exp;
        item_t it;
        @(negedge clk);
        #1;
        if (rst_n) begin
            req_exp = !halt_m && !redirect_valid && (q.size() < 2);
            check("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
            if (redirect_valid && !halt_m) begin
                q.delete();
                pc_m       = redirect_pc;
                dir_m      = redirect_dir;
                inflight_m = 0;
            end else begin
                if (inflight_m && q.size() > 0 && q[q.size()-1].word == HALT) halt_m = 1;
                if (req_exp) begin
                    check("imem_addr", {16'd0, imem_addr}, {16'd0, pc_m});
                    it.word = mem[pc_m];
                    it.addr = pc_m;
                    q.push_back(it);
                    pc_m = dir_m ? pc_m - 16'd1 : pc_m + 16'd1;
                end
                inflight_m = req_exp;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] target, input logic dir);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        redirect_dir   = dir;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] w;
        checks = 0; failures = 0; delivered = 0; halt_delivered = 0;
        rst_n = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0; redirect_dir = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            w = 9'($urandom);
            if (w == HALT) w = 9'h0AA;
            mem[i] = w;
        end
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003;
        model_reset();
        #1;
        reset_checks("reset");
        cycle();
        cycle();
        rst_n = 1'b1;

        // First word after two edges, then a 5-cycle stall with a full FIFO.
        cycle();
        cycle();
        stall = 1'b1;
        repeat (5) cycle();
        stall = 1'b0;
        repeat (6) cycle();

        // Backward redirects, including wrap through zero.
        redirect(16'h0010, 1'b1);
        repeat (6) cycle();
        redirect(16'h0000, 1'b1);
        repeat (6) cycle();

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 6) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
                redirect_dir   = 1'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) cycle();

        // Mid-run async reset, then a halt word at address 3.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks("async_reset");
        mem[3] = HALT;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stall = ($urandom_range(0, 99) < 25);
            cycle();
        end
        stall = 1'b0;
        repeat (4) cycle();
        redirect(16'h0040, 1'b0);
        repeat (6) cycle();
        check("halted_sticky", {31'd0, halted}, 32'd1);
        check("halt_word_delivered", {31'd0, halt_delivered}, 32'd1);
        check("delivered_min", {31'd0, (delivered >= 100)}, 32'd1);

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks("halt_reset");
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
